// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundles the pixel-advance enable and every timing output of
//   vga_timing_gen into one interface.
//
//   Parameter
//     CNT_W        counter / coordinate width (must match the generator)
//
//   Signals
//     pix_en       pixel-advance enable (consumer -> generator)
//     h_sync       horizontal sync, level set by the generator's H_POL
//     v_sync       vertical sync, level set by the generator's V_POL
//     active       current pixel is inside the visible window
//     x, y         current horizontal / vertical position
//     line_start   one-cycle strobe when x has just become 0
//     frame_start  one-cycle strobe when x and y have just become 0
//     frame_cnt    16-bit completed-frame counter; present only when
//                  VGA_TIMING_FRAME_CNT_EN is defined
//
//   Modports
//     master       the timing generator (drives everything except pix_en)
//     slave        the consumer (drives pix_en, observes the timing)
//
//   Handshake: there is no valid/ready pair. pix_en acts as a qualifier:
//   a rising clk_25 edge with pix_en=1 advances the position by one pixel;
//   with pix_en=0 the position and the level outputs hold and the strobes
//   drop to 0.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
) ();

  logic             pix_en;
  logic             h_sync;
  logic             v_sync;
  logic             active;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  modport master (
    input  pix_en,
    output h_sync, v_sync, active, x, y, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output pix_en,
    input  h_sync, v_sync, active, x, y, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator. It walks a pixel position (x, y) through
//   H_TOTAL x V_TOTAL positions and produces registered sync, visible-area
//   and start-of-line / start-of-frame strobes aligned with that position.
//
//   Ports
//     clk_25     pixel clock, all logic on the rising edge
//     reset_n    synchronous active-low reset
//     vga        vga_timing_gen_if.master: pix_en in; h_sync, v_sync,
//                active, x, y, line_start, frame_start (and frame_cnt) out
//
//   Optional feature
//     VGA_TIMING_FRAME_CNT_EN  when defined, adds a 16-bit frame_cnt output
//                              that increments each time y wraps to 0.
//
//   Line layout (frames use the same order in lines):
//     active | front porch | sync | back porch
//
//   Every output is a register loaded from the *next* position, so in any
//   cycle all outputs describe the x/y shown in that same cycle.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk_25,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Refuse to build a generator whose counters cannot hold a full line or
  // frame: the wrap compare would never match and the raster would run away.
  generate
    if (H_TOTAL > (2 ** CNT_W)) begin : g_h_total_chk
      $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL > (2 ** CNT_W)) begin : g_v_total_chk
      $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS_END    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Registered state
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic             h_sync_q;
  logic             v_sync_q;
  logic             active_q;
  logic             line_start_q;
  logic             frame_start_q;

  // Next position and its decode
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic             h_in_sync_nxt;
  logic             v_in_sync_nxt;
  logic             active_nxt;

  always_comb begin
    h_wrap = (x_q == H_LAST);
    v_wrap = (y_q == V_LAST);
    x_nxt  = h_wrap ? '0 : x_q + CNT_W'(1);
    y_nxt  = y_q;
    // y moves only on the pixel where x wraps back to 0.
    if (h_wrap) begin
      y_nxt = v_wrap ? '0 : y_q + CNT_W'(1);
    end
    h_in_sync_nxt = (x_nxt >= H_SYNC_FIRST) && (x_nxt <= H_SYNC_LAST);
    v_in_sync_nxt = (y_nxt >= V_SYNC_FIRST) && (y_nxt <= V_SYNC_LAST);
    active_nxt    = (x_nxt < H_VIS_END) && (y_nxt < V_VIS_END);
  end

  // Reset forces position (0,0) directly, which cuts any sync pulse in
  // progress at the reset edge rather than letting it finish.
  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      active_q      <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else if (vga.pix_en) begin
      x_q           <= x_nxt;
      y_q           <= y_nxt;
      h_sync_q      <= h_in_sync_nxt ? H_POL : ~H_POL;
      v_sync_q      <= v_in_sync_nxt ? V_POL : ~V_POL;
      active_q      <= active_nxt;
      line_start_q  <= (x_nxt == '0);
      frame_start_q <= (x_nxt == '0) && (y_nxt == '0);
    end else begin
      // Position and levels hold; strobes must not repeat while stalled.
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.h_sync      = h_sync_q;
  assign vga.v_sync      = v_sync_q;
  assign vga.active      = active_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Counts completed frames: the advance that takes (H_LAST, V_LAST) to
  // (0, 0). Wraps naturally at 16 bits.
  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (vga.pix_en && h_wrap && v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // Small raster with active-high syncs: full frames fit in a few hundred cycles.
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 4, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_W  = 5;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;   // 15
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;   // 8
  // Default 640x480 raster, active-low syncs.
  localparam int D_HT = 800, D_VT = 525;
  localparam int SW = 5 + 2 * S_W;
  localparam int DW = 5 + 20;

  // ---------------- clock / reset ----------------
  logic clk_25  = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_25 = ~clk_25;

  vga_timing_gen_if #(.CNT_W(S_W)) vs ();
  vga_timing_gen_if #(.CNT_W(10))  vd ();

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(S_W)
  ) dut_s (
    .clk_25  (clk_25),
    .reset_n (reset_n),
    .vga     (vs)
  );

  vga_timing_gen dut_d (
    .clk_25  (clk_25),
    .reset_n (reset_n),
    .vga     (vd)
  );

  // ---------------- scoreboard ----------------
  logic [SW-1:0] exp_s_q[$];
  logic [DW-1:0] exp_d_q[$];
  int total = 0;
  int bad   = 0;

  int  sx, sy, dx, dy;
  bit  s_adv, d_adv;

  function automatic logic [SW-1:0] exp_s(input int x, input int y, input bit adv);
    logic hs, vsy, act, ls, fs;
    hs  = (x >= 10 && x <= 12);          // sync columns 10..12, active high
    vsy = (y >= 5 && y <= 6);            // sync lines 5..6, active high
    act = (x < 8) && (y < 4);
    ls  = adv && (x == 0);
    fs  = ls && (y == 0);
    return {hs, vsy, act, ls, fs, S_W'(x), S_W'(y)};
  endfunction

  function automatic logic [DW-1:0] exp_d(input int x, input int y, input bit adv);
    logic hs, vsy, act, ls, fs;
    hs  = !(x >= 656 && x <= 751);       // active low
    vsy = !(y >= 490 && y <= 491);
    act = (x < 640) && (y < 480);
    ls  = adv && (x == 0);
    fs  = ls && (y == 0);
    return {hs, vsy, act, ls, fs, 10'(x), 10'(y)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, advance the reference position, queue the
  // expected outputs, then compare after the edge.
  task automatic step(input logic rst_v, input logic en);
    logic [SW-1:0] es;
    logic [DW-1:0] ed;
    reset_n   = rst_v;
    vs.pix_en = en;
    vd.pix_en = en;
    if (!rst_v) begin
      sx = 0; sy = 0; s_adv = 1'b1;
      dx = 0; dy = 0; d_adv = 1'b1;
    end else if (en) begin
      s_adv = 1'b1;
      d_adv = 1'b1;
      if (sx == S_HT - 1) begin sx = 0; sy = (sy == S_VT - 1) ? 0 : sy + 1; end
      else sx++;
      if (dx == D_HT - 1) begin dx = 0; dy = (dy == D_VT - 1) ? 0 : dy + 1; end
      else dx++;
    end else begin
      s_adv = 1'b0;
      d_adv = 1'b0;
    end
    exp_s_q.push_back(exp_s(sx, sy, s_adv));
    exp_d_q.push_back(exp_d(dx, dy, d_adv));
    @(posedge clk_25);
    #1;
    es = exp_s_q.pop_front();
    ed = exp_d_q.pop_front();
    chk("sb_small", 32'({vs.h_sync, vs.v_sync, vs.active, vs.line_start, vs.frame_start, vs.x, vs.y}), 32'(es));
    chk("sb_dflt",  32'({vd.h_sync, vd.v_sync, vd.active, vd.line_start, vd.frame_start, vd.x, vd.y}), 32'(ed));
  endtask

  // ---------------- directed sequence ----------------
  int s_act, s_hs, s_vs, s_ls, s_fs, s_fs_prev, s_fs_last;
  int d_hs, d_hmin, d_hmax, d_act, d_ls, d_ls_prev, d_ls_last, d_fs;
  int t_ls, t_ls_prev, t_ls_last, t_dbl;
  bit prev_ls;
  logic [S_W-1:0] hold_x, hold_y;

  initial begin
    // reset held for three edges
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("rst_x",      32'(vs.x), 32'd0);
    chk("rst_y",      32'(vs.y), 32'd0);
    chk("rst_hs_s",   32'(vs.h_sync), 32'd0);
    chk("rst_vs_s",   32'(vs.v_sync), 32'd0);
    chk("rst_hs_d",   32'(vd.h_sync), 32'd1);
    chk("rst_vs_d",   32'(vd.v_sync), 32'd1);
    chk("rst_active", 32'(vs.active), 32'd1);
    chk("rst_ls",     32'(vs.line_start), 32'd1);
    chk("rst_fs",     32'(vs.frame_start), 32'd1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("rst_fcnt",   32'(vs.frame_cnt), 32'd0);
`endif

    // free run: 20 small frames, 3 default lines
    s_act = 0; s_hs = 0; s_vs = 0; s_ls = 0; s_fs = 0; s_fs_prev = 0; s_fs_last = 0;
    d_hs = 0; d_hmin = 1000; d_hmax = -1; d_act = 0; d_ls = 0; d_ls_prev = 0; d_ls_last = 0; d_fs = 0;
    for (int i = 1; i <= 2400; i++) begin
      step(1'b1, 1'b1);
      if (vs.active) s_act++;
      if (vs.h_sync) s_hs++;
      if (vs.v_sync) s_vs++;
      if (vs.line_start) s_ls++;
      if (vs.frame_start) begin s_fs++; s_fs_prev = s_fs_last; s_fs_last = i; end
      if (!vd.h_sync) begin
        d_hs++;
        if (int'(vd.x) < d_hmin) d_hmin = int'(vd.x);
        if (int'(vd.x) > d_hmax) d_hmax = int'(vd.x);
      end
      if (vd.active) d_act++;
      if (vd.line_start) begin d_ls++; d_ls_prev = d_ls_last; d_ls_last = i; end
      if (vd.frame_start) d_fs++;
    end
    chk("s_active_cnt",   32'(s_act), 32'd640);
    chk("s_hsync_cnt",    32'(s_hs),  32'd480);
    chk("s_vsync_cnt",    32'(s_vs),  32'd600);
    chk("s_line_cnt",     32'(s_ls),  32'd160);
    chk("s_frame_cnt",    32'(s_fs),  32'd20);
    chk("s_frame_period", 32'(s_fs_last - s_fs_prev), 32'd120);
    chk("d_hlow_cnt",     32'(d_hs),   32'd288);
    chk("d_hlow_first",   32'(d_hmin), 32'd656);
    chk("d_hlow_last",    32'(d_hmax), 32'd751);
    chk("d_active_cnt",   32'(d_act),  32'd1920);
    chk("d_line_cnt",     32'(d_ls),   32'd3);
    chk("d_line_period",  32'(d_ls_last - d_ls_prev), 32'd800);
    chk("d_frame_strobe", 32'(d_fs),   32'd0);

    // pix_en alternating 1/0: line period doubles, strobes stay one cycle
    t_ls = 0; t_ls_prev = 0; t_ls_last = 0; t_dbl = 0; prev_ls = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
      if (vs.line_start) begin
        t_ls++; t_ls_prev = t_ls_last; t_ls_last = i;
        if (prev_ls) t_dbl++;
      end
      prev_ls = vs.line_start;
    end
    chk("tog_line_cnt",    32'(t_ls), 32'd4);
    chk("tog_line_period", 32'(t_ls_last - t_ls_prev), 32'd30);
    chk("tog_pulse_width", 32'(t_dbl), 32'd0);

    // long stall: position holds, strobes quiet
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    hold_x = vs.x;
    hold_y = vs.y;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("hold_x",  32'(vs.x), 32'(hold_x));
    chk("hold_y",  32'(vs.y), 32'(hold_y));
    chk("hold_ls", 32'(vs.line_start), 32'd0);

    // reset in the middle of both sync pulses
    for (int i = 0; i < S_HT * S_VT && !(sx == 11 && sy == 6); i++) step(1'b1, 1'b1);
    chk("pre_rst_hs", 32'(vs.h_sync), 32'd1);
    chk("pre_rst_vs", 32'(vs.v_sync), 32'd1);
    step(1'b0, 1'b1);
    chk("mid_rst_x",  32'(vs.x), 32'd0);
    chk("mid_rst_y",  32'(vs.y), 32'd0);
    chk("mid_rst_hs", 32'(vs.h_sync), 32'd0);
    chk("mid_rst_vs", 32'(vs.v_sync), 32'd0);
    chk("mid_rst_dx", 32'(vd.x), 32'd0);

    // three complete small frames after reset
    for (int i = 0; i < 3 * S_HT * S_VT; i++) step(1'b1, 1'b1);
    chk("end_x", 32'(vs.x), 32'd0);
    chk("end_y", 32'(vs.y), 32'd0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("fcnt_small", 32'(vs.frame_cnt), 32'd3);
    chk("fcnt_dflt",  32'(vd.frame_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
